// File: rtl/bcd_tick_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bcd_tick_counter
// Description : Four-digit BCD up/down counter. It advances on rising edges of a
//               divided clock that is sampled as data. Define TICK_SYNC_EN to
//               resynchronise I_TICK through two flops; otherwise one flop is used.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_tick_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  I_CLK,
    input  logic                  Rst_n,
    input  logic                  I_TICK,
    input  logic                  En,
    input  logic                  Up,
    input  logic                  Clr,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Load_val,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Carry,
    output logic                  Tick
);

    localparam int c_WIDTH = 4 * DIGITS;

    logic               r_s;
    logic               r_s_vld;
    logic               r_prev;
    logic               r_prev_vld;
    logic               w_strobe;
    logic [c_WIDTH-1:0] r_count;
    logic               r_carry;
    logic               r_tick;

    // The *_vld flags mark flops that hold a real sample rather than a reset
    // zero, so a tick already high at reset release is not taken as an edge.
`ifdef TICK_SYNC_EN
    logic r_sync1;
    logic r_sync1_vld;

    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1     <= 1'b0;
            r_sync1_vld <= 1'b0;
            r_s         <= 1'b0;
            r_s_vld     <= 1'b0;
        end else begin
            r_sync1     <= I_TICK;
            r_sync1_vld <= 1'b1;
            r_s         <= r_sync1;
            r_s_vld     <= r_sync1_vld;
        end
    end
`else
    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_s     <= 1'b0;
            r_s_vld <= 1'b0;
        end else begin
            r_s     <= I_TICK;
            r_s_vld <= 1'b1;
        end
    end
`endif

    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_prev     <= 1'b0;
            r_prev_vld <= 1'b0;
        end else begin
            r_prev     <= r_s;
            r_prev_vld <= r_s_vld;
        end
    end

    assign w_strobe = r_s & ~r_prev & r_prev_vld;

    logic [DIGITS:0]    w_cy;
    logic [DIGITS:0]    w_bw;
    logic [c_WIDTH-1:0] w_inc;
    logic [c_WIDTH-1:0] w_dec;
    logic [c_WIDTH-1:0] w_load;

    assign w_cy[0] = 1'b1;
    assign w_bw[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_d;
            logic [3:0] w_ld;

            assign w_d  = r_count[4*gi +: 4];
            assign w_ld = Load_val[4*gi +: 4];

            assign w_inc[4*gi +: 4] = !w_cy[gi]      ? w_d  :
                                      (w_d == 4'd9)  ? 4'd0 : w_d + 4'd1;
            assign w_cy[gi+1]       = w_cy[gi] & (w_d == 4'd9);

            assign w_dec[4*gi +: 4] = !w_bw[gi]      ? w_d  :
                                      (w_d == 4'd0)  ? 4'd9 : w_d - 4'd1;
            assign w_bw[gi+1]       = w_bw[gi] & (w_d == 4'd0);

            assign w_load[4*gi +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
        end
    endgenerate

    // A strobe that coincides with Clr or Load is dropped, never deferred.
    always_ff @(posedge I_CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= w_strobe;
            r_carry <= 1'b0;
            if (Clr) begin
                r_count <= '0;
            end else if (Load) begin
                r_count <= w_load;
            end else if (w_strobe && En) begin
                if (Up) begin
                    r_count <= w_inc;
                    r_carry <= w_cy[DIGITS];
                end else begin
                    r_count <= w_dec;
                    r_carry <= w_bw[DIGITS];
                end
            end
        end
    end

    assign Count = r_count;
    assign Carry = r_carry;
    assign Tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_bcd_tick_counter.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for bcd_tick_counter: table vectors, directed corner sequences and
// randomized stimulus checked against an integer-arithmetic reference model.
module tb_bcd_tick_counter;

`ifdef TICK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        I_CLK;
    logic        Rst_n;
    logic        I_TICK;
    logic        En;
    logic        Up;
    logic        Clr;
    logic        Load;
    logic [15:0] Load_val;
    logic [15:0] Count;
    logic        Carry;
    logic        Tick;

    bcd_tick_counter #(.DIGITS(4)) dut (
        .I_CLK    (I_CLK),
        .Rst_n    (Rst_n),
        .I_TICK   (I_TICK),
        .En       (En),
        .Up       (Up),
        .Clr      (Clr),
        .Load     (Load),
        .Load_val (Load_val),
        .Count    (Count),
        .Carry    (Carry),
        .Tick     (Tick)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    int n_vec;
    int n_err;
    int tick_seen;
    int carry_seen;

    // Reference model: count as an integer 0..9999, I_TICK samples in a queue.
    int m_count;
    bit m_carry;
    bit m_tick;
    bit hist[$];

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] v);
        int sum;
        int mult;
        int d;
        sum  = 0;
        mult = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            sum  = sum + d * mult;
            mult = mult * 10;
        end
        return sum;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_carry = 1'b0;
        m_tick  = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        bit strobe;
        hist.push_back(I_TICK);
        if (hist.size() > LAT + 2) void'(hist.pop_front());
        strobe  = (hist.size() == LAT + 2) && hist[1] && !hist[0];
        m_tick  = strobe;
        m_carry = 1'b0;
        if (Clr) begin
            m_count = 0;
        end else if (Load) begin
            m_count = clamp_val(Load_val);
        end else if (strobe && En) begin
            if (Up) begin
                if (m_count == 9999) begin m_count = 0; m_carry = 1'b1; end
                else m_count = m_count + 1;
            end else begin
                if (m_count == 0) begin m_count = 9999; m_carry = 1'b1; end
                else m_count = m_count - 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge I_CLK);
        model_edge();
        @(negedge I_CLK);
        chk("model_count", Count, to_bcd(m_count));
        chk("model_carry", {15'd0, Carry}, {15'd0, m_carry});
        chk("model_tick",  {15'd0, Tick},  {15'd0, m_tick});
        if (Tick)  tick_seen++;
        if (Carry) carry_seen++;
    endtask

    // One 80 ns I_TICK period: 4 cycles high, 4 low; Tick must land LAT edges
    // after the edge that first samples the high level.
    task automatic do_tick();
        I_TICK = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("tick_latency", {15'd0, Tick}, {15'd0, (i == LAT + 1)});
        end
        I_TICK = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic load_value(input logic [15:0] v);
        Load = 1'b1;
        Load_val = v;
        step();
        Load = 1'b0;
    endtask

    typedef struct {
        logic        clr;
        logic        load;
        logic [15:0] val;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int phase_left;

        tbl[0] = '{1'b0, 1'b1, 16'hA5F3, 16'h9593};
        tbl[1] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
        tbl[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000};
        tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h9999};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h9999};
        tbl[5] = '{1'b0, 1'b1, 16'h9B0C, 16'h9909};
        tbl[6] = '{1'b1, 1'b0, 16'h5555, 16'h0000};
        tbl[7] = '{1'b0, 1'b1, 16'hC0DE, 16'h9099};

        n_vec = 0; n_err = 0; tick_seen = 0; carry_seen = 0;
        Rst_n = 1'b0; I_TICK = 1'b1; En = 1'b1; Up = 1'b1;
        Clr = 1'b0; Load = 1'b0; Load_val = 16'h0000;
        model_reset();

        #200;
        chk("reset_count", Count, 16'h0000);
        chk("reset_carry", {15'd0, Carry}, 16'h0000);
        chk("reset_tick",  {15'd0, Tick},  16'h0000);
        @(negedge I_CLK);
        Rst_n = 1'b1;

        // I_TICK high across reset release must not count until it cycles low.
        for (int i = 0; i < 6; i++) step();
        chk("no_tick_after_reset", 16'(tick_seen), 16'd0);
        chk("no_count_after_reset", Count, 16'h0000);
        I_TICK = 1'b0;
        for (int i = 0; i < 4; i++) step();
        do_tick();
        chk("first_real_tick", Count, 16'h0001);

        for (int i = 0; i < 8; i++) begin
            Clr = tbl[i].clr; Load = tbl[i].load; Load_val = tbl[i].val;
            step();
            chk($sformatf("table%0d_count", i), Count, tbl[i].exp);
            chk($sformatf("table%0d_tick", i), {15'd0, Tick}, 16'h0000);
        end
        Clr = 1'b0; Load = 1'b0;

        // Up count from zero: five ticks, five Tick pulses.
        Clr = 1'b1; step(); Clr = 1'b0;
        En = 1'b1; Up = 1'b1; tick_seen = 0;
        for (int i = 0; i < 5; i++) do_tick();
        chk("up5_count", Count, 16'h0005);
        chk("up5_ticks", 16'(tick_seen), 16'd5);

        // Asynchronous reset mid-count at 0042.
        load_value(16'h0041);
        do_tick();
        chk("pre_reset_count", Count, 16'h0042);
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_count", Count, 16'h0000);
        chk("async_reset_carry", {15'd0, Carry}, 16'h0000);
        chk("async_reset_tick",  {15'd0, Tick},  16'h0000);
        @(negedge I_CLK);
        @(negedge I_CLK);
        Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step();

        // Up wrap 9998 -> 9999 -> 0000.
        load_value(16'h9998);
        carry_seen = 0;
        do_tick();
        chk("up_9999", Count, 16'h9999);
        do_tick();
        chk("up_wrap_count", Count, 16'h0000);
        chk("up_wrap_carry_pulses", 16'(carry_seen), 16'd1);

        // Down with digit borrow, then down wrap.
        Up = 1'b0;
        load_value(16'h1000);
        carry_seen = 0;
        do_tick();
        chk("down_borrow", Count, 16'h0999);
        chk("down_borrow_no_carry", 16'(carry_seen), 16'd0);
        load_value(16'h0000);
        do_tick();
        chk("down_wrap_count", Count, 16'h9999);
        chk("down_wrap_carry_pulses", 16'(carry_seen), 16'd1);

        // Clr on the strobe cycle: cleared, Tick still pulses, no deferred step.
        Up = 1'b1;
        load_value(16'h0123);
        I_TICK = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            Clr = (i == LAT + 1);
            step();
            if (i == LAT + 1) begin
                chk("clr_on_strobe_count", Count, 16'h0000);
                chk("clr_on_strobe_tick", {15'd0, Tick}, 16'h0001);
            end
        end
        Clr = 1'b0;
        I_TICK = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("clr_not_deferred", Count, 16'h0000);

        // En low: count holds while Tick keeps pulsing.
        load_value(16'h4567);
        En = 1'b0; tick_seen = 0;
        for (int i = 0; i < 3; i++) do_tick();
        chk("en0_count", Count, 16'h4567);
        chk("en0_ticks", 16'(tick_seen), 16'd3);

        // Randomized stimulus against the model.
        phase_left = 3;
        for (int c = 0; c < 600; c++) begin
            if (phase_left == 0) begin
                I_TICK = ~I_TICK;
                phase_left = $urandom_range(2, 5);
            end
            phase_left--;
            En   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) Up = ~Up;
            Clr  = ($urandom_range(0, 31) == 0);
            Load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       Load_val = 16'h9999;
                1:       Load_val = 16'h0000;
                default: Load_val = 16'($urandom);
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
